// File: rtl/ldtu_ser_lane_aligner.sv
// Receiver for one LiTE-DTU serializer lane: hunts for the sync word in the
// MSB-first bit stream, confirms alignment, then emits aligned 32-bit words.
module ldtu_ser_lane_aligner #(
  parameter logic [31:0] SYNC_WORD = 32'hEAAAAAAA,
  parameter int unsigned LOCK_CNT  = 4,
  parameter int unsigned MAX_GAP   = 256
) (
  input  logic        clock,
  input  logic        rst_b,
  input  logic        serial_in,
  input  logic        realign,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic        is_idle,
  output logic        locked,
  output logic        lock_lost,
  output logic [7:0]  lock_lost_cnt
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam logic [3:0]  LOCK_N = 4'(LOCK_CNT);
  localparam logic [16:0] GAP_N  = 17'(MAX_GAP);

  state_t      state;
  logic [31:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic [3:0]  match_cnt;
  logic [15:0] gap_cnt;
  logic        is_sync;
  logic        aligned;
  logic        gap_hit;
  logic        lose_lock;

  assign is_sync = (shift_reg == SYNC_WORD);
  assign aligned = (state != HUNT) && (bit_cnt == 5'd0);
  assign gap_hit = (MAX_GAP != 0) && (({1'b0, gap_cnt} + 17'd1) >= GAP_N);

  // realign wins over everything; otherwise only a non-sync locked word can drop lock
  assign lose_lock = (state == LOCKED) &&
                     (realign || (aligned && !is_sync && gap_hit));

  always_ff @(posedge clock or negedge rst_b) begin
    if (!rst_b) begin
      state         <= HUNT;
      shift_reg     <= 32'h0;
      bit_cnt       <= 5'd0;
      match_cnt     <= 4'd0;
      gap_cnt       <= 16'd0;
      data_out      <= 32'h0;
      data_valid    <= 1'b0;
      is_idle       <= 1'b0;
      locked        <= 1'b0;
      lock_lost     <= 1'b0;
      lock_lost_cnt <= 8'h0;
    end else begin
      shift_reg  <= {shift_reg[30:0], serial_in};
      data_valid <= 1'b0;
      is_idle    <= 1'b0;
      lock_lost  <= lose_lock;
      if (lose_lock && (lock_lost_cnt != 8'hFF))
        lock_lost_cnt <= lock_lost_cnt + 8'd1;

      if (realign) begin
        state     <= HUNT;
        locked    <= 1'b0;
        bit_cnt   <= 5'd0;
        match_cnt <= 4'd0;
        gap_cnt   <= 16'd0;
      end else begin
        case (state)
          HUNT: begin
            bit_cnt <= 5'd0;
            if (is_sync) begin
              // the sync word just completed, so the next bit starts a new word
              bit_cnt   <= 5'd1;
              match_cnt <= 4'd1;
              gap_cnt   <= 16'd0;
              if (LOCK_CNT == 1) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                state <= VERIFY;
              end
            end
          end

          VERIFY: begin
            bit_cnt <= bit_cnt + 5'd1;
            if (aligned) begin
              if (is_sync) begin
                match_cnt <= match_cnt + 4'd1;
                if ((match_cnt + 4'd1) == LOCK_N) begin
                  state   <= LOCKED;
                  locked  <= 1'b1;
                  gap_cnt <= 16'd0;
                end
              end else begin
                state     <= HUNT;
                bit_cnt   <= 5'd0;
                match_cnt <= 4'd0;
              end
            end
          end

          LOCKED: begin
            bit_cnt <= bit_cnt + 5'd1;
            if (aligned) begin
              data_out   <= shift_reg;
              data_valid <= 1'b1;
              is_idle    <= is_sync;
              if (is_sync) begin
                gap_cnt <= 16'd0;
              end else if (gap_hit) begin
                // this word is still delivered; the lane then re-hunts
                state     <= HUNT;
                locked    <= 1'b0;
                bit_cnt   <= 5'd0;
                match_cnt <= 4'd0;
                gap_cnt   <= 16'd0;
              end else begin
                gap_cnt <= gap_cnt + 16'd1;
              end
            end
          end

          default: begin
            state   <= HUNT;
            locked  <= 1'b0;
            bit_cnt <= 5'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ldtu_ser_lane_aligner.sv
// Bench for ldtu_ser_lane_aligner: drives a serial lane and checks strobed
// words, their timing, lock tracking and the lock-loss counter.
module tb_ldtu_ser_lane_aligner;

  localparam logic [31:0] SYNC = 32'hEAAAAAAA;

  typedef struct packed {
    logic [31:0] word;
    logic        idle;
    int          cyc;
  } exp_t;

  logic        clock = 1'b0;
  logic        rst_b = 1'b0;
  logic        serial_in = 1'b0;
  logic        realign = 1'b0;
  logic [31:0] data_out;
  logic        data_valid;
  logic        is_idle;
  logic        locked;
  logic        lock_lost;
  logic [7:0]  lock_lost_cnt;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  logic [7:0] exp_lost = 8'h0;
  exp_t sb[$];
  exp_t e;

  ldtu_ser_lane_aligner #(
    .SYNC_WORD(SYNC),
    .LOCK_CNT(4),
    .MAX_GAP(16)
  ) dut (
    .clock(clock),
    .rst_b(rst_b),
    .serial_in(serial_in),
    .realign(realign),
    .data_out(data_out),
    .data_valid(data_valid),
    .is_idle(is_idle),
    .locked(locked),
    .lock_lost(lock_lost),
    .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard: every strobe must match the oldest expected word and its cycle
  always @(negedge clock) begin
    if (rst_b) begin
      n_checks++;
      if (!data_valid && is_idle) begin
        n_errors++;
        $display("FAIL idle_without_valid is_idle=%b required 0", is_idle);
      end
      if (data_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_strobe data_out=%h cycle=%0d required no strobe", data_out, cyc);
        end else begin
          e = sb.pop_front();
          if (data_out !== e.word || is_idle !== e.idle || cyc !== e.cyc) begin
            n_errors++;
            $display("FAIL strobe data_out=%h is_idle=%b cycle=%0d required %h %b %0d",
                     data_out, is_idle, cyc, e.word, e.idle, e.cyc);
          end
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    serial_in = b;
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input bit expect_strobe);
    exp_t x;
    if (expect_strobe) begin
      x.word = w;
      x.idle = (w == SYNC);
      x.cyc  = cyc + 33;
      sb.push_back(x);
    end
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic lock_up(input string tag);
    for (int i = 0; i < 4; i++) send_word(SYNC, 1'b0);
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL %s_locked_early locked=%b required 0", tag, locked);
    end
    send_word(SYNC, 1'b1);
    n_checks++;
    if (locked !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_locked locked=%b required 1", tag, locked);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if ({data_out, data_valid, is_idle, locked, lock_lost, lock_lost_cnt} !== 44'h0) begin
      n_errors++;
      $display("FAIL reset_outputs data_out=%h valid=%b idle=%b locked=%b lost=%b cnt=%h required all 0",
               data_out, data_valid, is_idle, locked, lock_lost, lock_lost_cnt);
    end
    rst_b = 1'b1;
    exp_lost = 8'h0;
  endtask

  task automatic test_acquire();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    lock_up("acquire");
    send_word(SYNC, 1'b1);
  endtask

  task automatic test_data_idle();
    send_word(32'h12345678, 1'b1);
    send_word(SYNC, 1'b1);
    n_checks++;
    if (data_out !== 32'h12345678 || data_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL data_hold data_out=%h valid=%b required 12345678 0", data_out, data_valid);
    end
  endtask

  task automatic test_realign();
    logic [31:0] w;
    w = SYNC;
    send_word(32'hA5A50F0F, 1'b0);
    realign = 1'b1;
    send_bit(w[31]);
    realign = 1'b0;
    exp_lost = exp_lost + 8'd1;
    n_checks++;
    if (data_valid !== 1'b0 || lock_lost !== 1'b1 || locked !== 1'b0) begin
      n_errors++;
      $display("FAIL realign_pulse valid=%b lost=%b locked=%b required 0 1 0", data_valid, lock_lost, locked);
    end
    n_checks++;
    if (lock_lost_cnt !== exp_lost) begin
      n_errors++;
      $display("FAIL realign_cnt cnt=%h required %h", lock_lost_cnt, exp_lost);
    end
    for (int i = 30; i >= 0; i--) send_bit(w[i]);
    for (int i = 0; i < 3; i++) send_word(SYNC, 1'b0);
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL realign_relock_early locked=%b required 0", locked);
    end
    send_word(SYNC, 1'b1);
    n_checks++;
    if (locked !== 1'b1) begin
      n_errors++;
      $display("FAIL realign_relock locked=%b required 1", locked);
    end
  endtask

  task automatic test_verify_fail();
    send_bit(1'b0);
    realign = 1'b1;
    send_bit(1'b0);
    realign = 1'b0;
    exp_lost = exp_lost + 8'd1;
    n_checks++;
    if (lock_lost !== 1'b1 || lock_lost_cnt !== exp_lost) begin
      n_errors++;
      $display("FAIL verify_drop lost=%b cnt=%h required 1 %h", lock_lost, lock_lost_cnt, exp_lost);
    end
    send_word(SYNC, 1'b0);
    send_word(32'hEAAAAAAB, 1'b0);
    n_checks++;
    if (locked !== 1'b0) begin
      n_errors++;
      $display("FAIL verify_corrupt locked=%b required 0", locked);
    end
    lock_up("verify_relock");
    n_checks++;
    if (lock_lost_cnt !== exp_lost) begin
      n_errors++;
      $display("FAIL verify_cnt cnt=%h required %h", lock_lost_cnt, exp_lost);
    end
  endtask

  task automatic test_reset_mid_word(input string tag);
    logic [31:0] w;
    w = 32'h12345678;
    for (int i = 31; i >= 22; i--) send_bit(w[i]);
    rst_b = 1'b0;
    #1;
    n_checks++;
    if ({data_out, data_valid, is_idle, locked, lock_lost, lock_lost_cnt} !== 44'h0) begin
      n_errors++;
      $display("FAIL %s_async_clear data_out=%h valid=%b idle=%b locked=%b lost=%b cnt=%h required all 0",
               tag, data_out, data_valid, is_idle, locked, lock_lost, lock_lost_cnt);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL %s_pending_words count=%0d required 0", tag, sb.size());
      sb.delete();
    end
    @(posedge clock);
    #1;
    rst_b = 1'b1;
    exp_lost = 8'h0;
    for (int i = 0; i < 40; i++) send_bit(i[0]);
    n_checks++;
    if ({data_out, data_valid, is_idle, locked, lock_lost, lock_lost_cnt} !== 44'h0) begin
      n_errors++;
      $display("FAIL %s_restart data_out=%h valid=%b locked=%b cnt=%h required all 0",
               tag, data_out, data_valid, locked, lock_lost_cnt);
    end
  endtask

  task automatic test_max_gap();
    lock_up("gap");
    for (int i = 0; i < 15; i++) send_word(32'h00000001, 1'b1);
    n_checks++;
    if (locked !== 1'b1) begin
      n_errors++;
      $display("FAIL gap_early_loss locked=%b required 1", locked);
    end
    send_word(32'h00000001, 1'b1);
    send_bit(1'b1);
    exp_lost = exp_lost + 8'd1;
    n_checks++;
    if (locked !== 1'b0 || lock_lost !== 1'b1 || lock_lost_cnt !== exp_lost) begin
      n_errors++;
      $display("FAIL gap_loss locked=%b lost=%b cnt=%h required 0 1 %h",
               locked, lock_lost, lock_lost_cnt, exp_lost);
    end
    send_bit(1'b1);
    n_checks++;
    if (lock_lost !== 1'b0) begin
      n_errors++;
      $display("FAIL gap_pulse_width lost=%b required 0", lock_lost);
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) send_word(SYNC, 1'b0);
      send_bit(1'b1);
      realign = 1'b1;
      send_bit(1'b1);
      realign = 1'b0;
      if (exp_lost != 8'hFF) exp_lost = exp_lost + 8'd1;
      n_checks++;
      if (lock_lost !== 1'b1 || lock_lost_cnt !== exp_lost) begin
        n_errors++;
        $display("FAIL sat_iter%0d lost=%b cnt=%h required 1 %h", n, lock_lost, lock_lost_cnt, exp_lost);
      end
    end
    n_checks++;
    if (lock_lost_cnt !== 8'hFF) begin
      n_errors++;
      $display("FAIL sat_final cnt=%h required ff", lock_lost_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_data_idle();
    test_realign();
    test_verify_fail();
    test_reset_mid_word("mid");
    test_max_gap();
    test_saturation();
    test_reset_mid_word("end");
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL missing_strobes count=%0d required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ldtu_ser_lane_aligner.md
Name: ldtu_ser_lane_aligner

Overview:
- Downstream receiver for one serial output lane of the LiTE-DTU serializer block, used in the system bench and the FPGA readout model.
- Shifts in one serial bit per clock, MSB first, and hunts for the idle/sync word.
- Confirms alignment over several consecutive word boundaries, then delivers aligned 32-bit words with a valid strobe.
- Detects loss of lock and counts lock losses; one instance per lane (four per chip).

Parameters:
- SYNC_WORD, 32'hEAAAAAAA, idle pattern transmitted on the lane when no data is pending.
- LOCK_CNT, 4, consecutive boundary matches required to declare lock (range 1..15).
- MAX_GAP, 256, consecutive non-sync locked words that force loss of lock; 0 disables this check (range 0..65535).

Ports:
- clock  in  1  serial bit clock (CLK_SRL domain); the only clock.
- rst_b  in  1  asynchronous reset, active low.
- serial_in  in  1  lane bit, MSB of each word first.
- realign  in  1  synchronous request to drop lock and re-hunt; level-sensitive.
- data_out  out  32  last aligned word.
- data_valid  out  1  one-cycle strobe, data_out updated.
- is_idle  out  1  qualifies data_valid: the word equals SYNC_WORD.
- locked  out  1  high in LOCKED state.
- lock_lost  out  1  one-cycle pulse on every LOCKED->HUNT exit.
- lock_lost_cnt  out  8  saturating count of lock_lost pulses.

Behaviour:
- Reset (async, rst_b=0): shift_reg=0, bit_cnt=0, match_cnt=0, gap_cnt=0, state=HUNT. All outputs 0, including data_out=32'h0 and lock_lost_cnt=0.
- Shift: shift_reg <= {shift_reg[30:0], serial_in} every cycle in every state.
- bit_cnt (5 bit): in HUNT it is held at 0. In VERIFY and LOCKED it increments mod 32. An aligned cycle is any non-HUNT cycle with bit_cnt==0.
- HUNT:
  - If shift_reg==SYNC_WORD: go to VERIFY, set bit_cnt<=1, match_cnt<=1.
  - If LOCK_CNT==1: go directly to LOCKED instead, with gap_cnt<=0.
- VERIFY, on an aligned cycle:
  - shift_reg==SYNC_WORD: match_cnt++. When it reaches LOCK_CNT, go to LOCKED with gap_cnt<=0.
  - Otherwise: return to HUNT, match_cnt<=0.
  - No data_valid is ever issued in VERIFY.
- LOCKED, on an aligned cycle:
  - Next edge: data_out<=shift_reg, data_valid=1, is_idle=(shift_reg==SYNC_WORD).
  - Output latency is 1 clock after the aligned cycle, i.e. 33 clocks after the word's MSB enters serial_in.
  - Sync word: gap_cnt<=0. Otherwise gap_cnt++.
  - If MAX_GAP!=0 and gap_cnt reaches MAX_GAP: that word is still output, then go to HUNT with a lock_lost pulse.
- locked is registered: high from the first edge entering LOCKED, low from the first edge leaving it.
- realign=1 in any state: next state HUNT, match_cnt and gap_cnt cleared, bit_cnt 0.
  - realign overrides a simultaneous aligned cycle, so no data_valid is issued.
  - lock_lost pulses only if the state was LOCKED.
  - realign held high keeps the block in HUNT.
- lock_lost_cnt increments on each lock_lost pulse and saturates at 8'hFF; it is cleared only by rst_b.
- data_out holds its value between strobes. is_idle is 0 whenever data_valid=0.
- Reset asserted mid-word aborts immediately. After release the block restarts in HUNT; no partial word is emitted.

Test Plan:
- Reset, then 3 bits of garbage followed by SYNC_WORD repeated 6 times:
  - HUNT matches after the first full sync word; locked rises after LOCK_CNT=4 aligned matches.
  - Two data_valid strobes follow, each with data_out=32'hEAAAAAAA and is_idle=1.
- Locked lane sends 32'h12345678 then 32'hEAAAAAAA:
  - data_valid occurs 33 clocks after the first bit, with data_out=32'h12345678 and is_idle=0.
  - The next strobe comes exactly 32 clocks later with is_idle=1.
- VERIFY with the 2nd boundary word corrupted to 32'hEAAAAAAB: return to HUNT, locked stays 0, no data_valid; relock after 4 clean syncs.
- MAX_GAP=16, locked, 16 consecutive 32'h00000001 words:
  - All 16 are strobed.
  - Then locked falls, lock_lost pulses once, and lock_lost_cnt=1.
- realign pulsed on an aligned cycle while locked: no strobe that cycle, lock_lost=1, lock_lost_cnt increments; relock then requires LOCK_CNT syncs.
- Force 300 lock losses: lock_lost_cnt saturates at 8'hFF. rst_b low mid-word clears all outputs asynchronously, before the next clock edge.
